// File: rtl/imm_encode_loader.sv
// rtl/imm_encode_loader.sv - immediate field encoder and sequential instruction-memory word loader
module imm_encode_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 64,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_imm_src,
    input  logic [31:0]   in_imm,
    input  logic [31:0]   in_base,
    output logic          wr_en,
    output logic [31:0]   wr_addr,
    output logic [31:0]   wr_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          err,
    output logic [7:0]    err_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENC   = 2'd1,
        S_WRITE = 2'd2,
        S_FULL  = 2'd3
    } state_t;

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;
    localparam logic [1:0] FMT_J = 2'b11;

    state_t      state, state_nxt;
    logic [1:0]  src_q;
    logic [31:0] imm_q;
    logic [31:0] base_q;
    logic        imm_ok;
    logic [31:0] enc_word;
    logic        capture;
    logic        load_word;
    logic        reject;
    logic        commit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        capture   = 1'b0;
        load_word = 1'b0;
        reject    = 1'b0;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture   = 1'b1;
                    state_nxt = S_ENC;
                end
            end
            S_ENC: begin
                if (imm_ok) begin
                    load_word = 1'b1;
                    state_nxt = S_WRITE;
                end else begin
                    reject    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                commit    = 1'b1;
                state_nxt = (count == CW'(DEPTH - 1)) ? S_FULL : S_IDLE;
            end
            S_FULL: begin
                state_nxt = S_FULL;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Range check is a sign-extension test on the bits above the field's top bit.
    always_comb begin
        imm_ok   = 1'b0;
        enc_word = base_q;
        case (src_q)
            FMT_I: begin
                imm_ok   = (imm_q[31:11] == {21{imm_q[11]}});
                enc_word = {imm_q[11:0], base_q[19:0]};
            end
            FMT_S: begin
                imm_ok   = (imm_q[31:11] == {21{imm_q[11]}});
                enc_word = {imm_q[11:5], base_q[24:12], imm_q[4:0], base_q[6:0]};
            end
            FMT_B: begin
                imm_ok   = (imm_q[31:12] == {20{imm_q[12]}}) && !imm_q[0];
                enc_word = {imm_q[12], imm_q[10:5], base_q[24:12], imm_q[4:1],
                            imm_q[11], base_q[6:0]};
            end
            FMT_J: begin
                imm_ok   = (imm_q[31:20] == {12{imm_q[20]}}) && !imm_q[0];
                enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12],
                            base_q[11:0]};
            end
            default: begin
                imm_ok   = 1'b0;
                enc_word = base_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q     <= 2'b00;
            imm_q     <= 32'd0;
            base_q    <= 32'd0;
            wr_en     <= 1'b0;
            wr_addr   <= BASE_ADDR;
            wr_data   <= 32'd0;
            count     <= '0;
            err       <= 1'b0;
            err_count <= 8'd0;
        end else begin
            wr_en <= load_word;
            if (capture) begin
                src_q  <= in_imm_src;
                imm_q  <= in_imm;
                base_q <= in_base;
            end
            if (load_word) begin
                wr_data <= enc_word;
            end
            // wr_addr tracks BASE_ADDR + 4*count so the write strobe needs no adder.
            if (commit) begin
                count   <= count + CW'(1);
                wr_addr <= wr_addr + 32'd4;
            end
            if (reject) begin
                err <= 1'b1;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

    assign full = (count == CW'(DEPTH));

endmodule

// File: tb/tb_imm_encode_loader.sv
// tb/tb_imm_encode_loader.sv - self-checking bench for imm_encode_loader
module tb_imm_encode_loader;

    localparam int DEPTH = 64;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_imm_src;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [6:0]  count;
    logic        full;
    logic        err;
    logic [7:0]  err_count;

    logic        rst2;
    logic        in_valid2;
    logic        in_ready2;
    logic [1:0]  in_imm_src2;
    logic [31:0] in_imm2;
    logic [31:0] in_base2;
    logic        wr_en2;
    logic [31:0] wr_addr2;
    logic [31:0] wr_data2;
    logic [1:0]  count2;
    logic        full2;
    logic        err2;
    logic [7:0]  err_count2;

    always #5 clk = ~clk;

    imm_encode_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm_src(in_imm_src), .in_imm(in_imm), .in_base(in_base),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .count(count),
        .full(full), .err(err), .err_count(err_count)
    );

    imm_encode_loader #(.BASE_ADDR(32'h0000_1000), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_imm_src(in_imm_src2), .in_imm(in_imm2), .in_base(in_base2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .count(count2),
        .full(full2), .err(err2), .err_count(err_count2)
    );

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    int exp_errc = 0;
    bit exp_err = 1'b0;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] base;
        logic        ok;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [1:0] src, input logic [31:0] imm);
        int signed v;
        v = signed'(imm);
        case (src)
            2'b00, 2'b01: return (v >= -2048) && (v <= 2047);
            2'b10:        return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
            default:      return (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
        endcase
    endfunction

    // The core's immediate sign-extension unit.
    function automatic logic [31:0] decode(input logic [1:0] src, input logic [31:0] w);
        case (src)
            2'b00:   return {{20{w[31]}}, w[31:20]};
            2'b01:   return {{20{w[31]}}, w[31:25], w[11:7]};
            2'b10:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] field_mask(input logic [1:0] src);
        case (src)
            2'b00:   return 32'hFFF0_0000;
            2'b01:   return 32'hFE00_0F80;
            2'b10:   return 32'hFE00_0F80;
            default: return 32'hFFFF_F000;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_count = 0;
        exp_errc  = 0;
        exp_err   = 1'b0;
    endtask

    task automatic send(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base,
                        input bit exp_ok, input bit chk_data, input logic [31:0] exp_data);
        check("ready_before", in_ready, 1);
        in_valid = 1'b1;
        in_imm_src = src;
        in_imm = imm;
        in_base = base;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_imm = $urandom;
        in_base = $urandom;
        in_imm_src = 2'($urandom);
        check("enc_ready", in_ready, 0);
        check("enc_wr_en", wr_en, 0);
        @(posedge clk);
        #1;
        check("wr_en", wr_en, exp_ok);
        if (exp_ok) begin
            check("write_ready", in_ready, 0);
            check("wr_addr", wr_addr, BASE + 32'(4 * exp_count));
            check("roundtrip", decode(src, wr_data), imm);
            check("base_bits", wr_data & ~field_mask(src), base & ~field_mask(src));
            if (chk_data) check("wr_data", wr_data, exp_data);
            exp_count++;
        end else begin
            exp_err = 1'b1;
            if (exp_errc < 255) exp_errc++;
            check("rej_ready", in_ready, 1);
            check("rej_err", err, 1);
        end
        @(posedge clk);
        #1;
        check("count", count, exp_count);
        check("full", full, exp_count == DEPTH);
        check("ready_after", in_ready, exp_count != DEPTH);
        check("err", err, exp_err);
        check("err_count", err_count, exp_errc);
    endtask

    initial begin
        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1, 32'hFFF0_0013};
        vecs[1]  = '{2'b00, 32'd2047,      32'h0000_0013, 1'b1, 32'h7FF0_0013};
        vecs[2]  = '{2'b00, -32'sd2048,    32'h0000_0013, 1'b1, 32'h8000_0013};
        vecs[3]  = '{2'b00, -32'sd2049,    32'h0000_0013, 1'b0, 32'h0};
        vecs[4]  = '{2'b01, -32'sd2048,    32'h0000_2023, 1'b1, 32'h8000_2023};
        vecs[5]  = '{2'b01, 32'd2048,      32'h0000_2023, 1'b0, 32'h0};
        vecs[6]  = '{2'b10, 32'd4094,      32'h0000_0063, 1'b1, 32'h7E00_0FE3};
        vecs[7]  = '{2'b10, -32'sd4096,    32'h0000_0063, 1'b1, 32'h8000_0063};
        vecs[8]  = '{2'b10, 32'd4096,      32'h0000_0063, 1'b0, 32'h0};
        vecs[9]  = '{2'b11, 32'd2048,      32'h0000_006F, 1'b1, 32'h0010_006F};
        vecs[10] = '{2'b11, 32'd1048574,   32'h0000_006F, 1'b1, 32'h7FFF_F06F};
        vecs[11] = '{2'b11, -32'sd1048576, 32'h0000_006F, 1'b1, 32'h8000_006F};
        vecs[12] = '{2'b11, 32'd1048576,   32'h0000_006F, 1'b0, 32'h0};
        vecs[13] = '{2'b11, 32'd1,         32'h0000_006F, 1'b0, 32'h0};
        vecs[14] = '{2'b00, 32'd0,         32'hFFFF_FFFF, 1'b1, 32'h000F_FFFF};
        vecs[15] = '{2'b01, 32'd0,         32'hFFFF_FFFF, 1'b1, 32'h01FF_F07F};
        vecs[16] = '{2'b10, 32'd0,         32'hFFFF_FFFF, 1'b1, 32'h01FF_F07F};
        vecs[17] = '{2'b11, 32'd0,         32'hFFFF_FFFF, 1'b1, 32'h0000_0FFF};

        rst = 1'b1; in_valid = 1'b0; in_imm_src = 2'b00; in_imm = 32'd0; in_base = 32'd0;
        rst2 = 1'b1; in_valid2 = 1'b0; in_imm_src2 = 2'b00; in_imm2 = 32'd0; in_base2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rst2 = 1'b0;

        check("rst_ready", in_ready, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, BASE);
        check("rst_wr_data", wr_data, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        check("rst_err_count", err_count, 0);

        // Back-to-back S then B, then the two rejected requests.
        send(2'b01, 32'd8, 32'h0000_2023, 1'b1, 1'b1, 32'h0000_2423);
        send(2'b10, -32'sd4, 32'h0000_0063, 1'b1, 1'b1, 32'hFE00_0EE3);
        check("b_addr_lit", wr_addr, 32'h0000_0008);
        send(2'b00, 32'd2048, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        send(2'b10, 32'd3, 32'h0000_0063, 1'b0, 1'b0, 32'h0);
        check("two_errs", err_count, 8'd2);
        check("two_words", count, 2);

        for (int i = 0; i < 18; i++) begin
            send(vecs[i].src, vecs[i].imm, vecs[i].base, vecs[i].ok, vecs[i].ok, vecs[i].data);
        end

        // rst during ENC aborts the word.
        do_reset();
        in_valid = 1'b1; in_imm_src = 2'b00; in_imm = 32'd5; in_base = 32'h13;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (wr_en) seen = 1'b1;
                @(posedge clk);
                #1;
            end
            check("enc_abort_wr_en", seen, 0);
        end
        check("enc_abort_count", count, 0);
        check("enc_abort_ready", in_ready, 1);

        // rst during WRITE drops the strobe and the increment.
        send(2'b00, 32'd1, 32'h13, 1'b1, 1'b0, 32'h0);
        in_valid = 1'b1; in_imm_src = 2'b00; in_imm = 32'd7; in_base = 32'h13;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("wr_abort_strobe", wr_en, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("wr_abort_wr_en", wr_en, 0);
        @(posedge clk);
        #1;
        check("wr_abort_count", count, 0);
        check("wr_abort_addr", wr_addr, BASE);
        exp_count = 0; exp_err = 1'b0; exp_errc = 0;

        // Randomized requests against the model, filling to FULL at least once.
        for (int n = 0; n < 150; n++) begin
            logic [1:0]  s;
            logic [31:0] v;
            if (exp_count == DEPTH) begin
                check("rand_full", full, 1);
                check("rand_full_ready", in_ready, 0);
                do_reset();
            end
            s = 2'($urandom);
            if ($urandom_range(0, 9) < 7) begin
                case (s)
                    2'b00, 2'b01: v = 32'(int'($urandom_range(0, 4095)) - 2048);
                    2'b10:        v = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
                    default:      v = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
                endcase
            end else begin
                v = $urandom;
            end
            send(s, v, $urandom, legal(s, v), 1'b0, 32'h0);
        end

        // err_count saturation.
        do_reset();
        for (int n = 0; n < 258; n++) begin
            send(2'b00, 32'd5000, 32'h13, 1'b0, 1'b0, 32'h0);
        end
        check("sat_err_count", err_count, 8'd255);
        check("sat_err", err, 1);

        // DEPTH=2 instance: fill, ignore further requests, reset.
        for (int i = 0; i < 2; i++) begin
            check("d2_ready", in_ready2, 1);
            in_valid2 = 1'b1; in_imm_src2 = 2'b00; in_imm2 = 32'(i); in_base2 = 32'h13;
            @(posedge clk);
            #1;
            in_valid2 = 1'b0;
            @(posedge clk);
            #1;
            check("d2_wr_en", wr_en2, 1);
            check("d2_wr_addr", wr_addr2, 32'h0000_1000 + 32'(4 * i));
            check("d2_wr_data", wr_data2, {12'(i), 20'h00013});
            @(posedge clk);
            #1;
        end
        check("d2_full", full2, 1);
        check("d2_full_ready", in_ready2, 0);
        check("d2_count", count2, 2);
        in_valid2 = 1'b1;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1;
                if (wr_en2) seen = 1'b1;
            end
            check("d2_ignored", seen, 0);
        end
        in_valid2 = 1'b0;
        check("d2_count_hold", count2, 2);
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        check("d2_rst_count", count2, 0);
        check("d2_rst_addr", wr_addr2, 32'h0000_1000);
        check("d2_rst_full", full2, 0);
        check("d2_rst_ready", in_ready2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
